// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ write requesters into one FIFO
// write port, tracking ack/overflow/timeout per transaction.
module fifo_wr_arbiter #(
   parameter int FIFO_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int TIMEOUT    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            done,
   output logic [NUM_REQ-1:0]            err,
   output logic                          busy,
   output logic                          wr_en,
   output logic [FIFO_WIDTH-1:0]         data_in,
   input  logic                          full,
   input  logic                          wr_ack,
   input  logic                          overflow,
   output logic [7:0]                    drop_cnt
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] cur_id;
   logic [IW-1:0] last_id;
   logic [IW-1:0] win_id;
   logic          win_vld;
   logic [TW-1:0] timer;

   // Descending scan so the nearest requester after last_id is written last.
   always_comb begin
      int idx;
      win_vld = 1'b0;
      win_id  = last_id;
      idx     = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_id) + k) % NUM_REQ;
         if (req[idx]) begin
            win_vld = 1'b1;
            win_id  = IW'(idx);
         end
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_en    <= 1'b0;
         data_in  <= '0;
         done     <= '0;
         err      <= '0;
         drop_cnt <= 8'd0;
         cur_id   <= '0;
         last_id  <= IW'(NUM_REQ - 1);
         timer    <= '0;
      end else begin
         done <= '0;
         err  <= '0;
         unique case (state)
            IDLE: begin
               if (win_vld && !full) begin
                  wr_en   <= 1'b1;
                  data_in <= req_data[win_id*FIFO_WIDTH +: FIFO_WIDTH];
                  cur_id  <= win_id;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               wr_en <= 1'b0;
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // Overflow wins over a simultaneous ack; ack wins over timeout.
               if (overflow) begin
                  err[cur_id] <= 1'b1;
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  last_id <= cur_id;
                  state   <= IDLE;
               end else if (wr_ack) begin
                  done[cur_id] <= 1'b1;
                  last_id <= cur_id;
                  state   <= IDLE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  err[cur_id] <= 1'b1;
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  last_id <= cur_id;
                  state   <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, width of each write word.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of write requesters; fixed at 4 in this revision.
REQ-003 SHALL have parameter TIMEOUT, default 4, number of WAIT cycles allowed for a FIFO response.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  in  NUM_REQ  per-requester write request; held until that requester's done or err.
REQ-007 SHALL have port req_data  in  NUM_REQ*FIFO_WIDTH  requester i's word in bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 SHALL have port done  out  NUM_REQ  one-cycle pulse: the word was accepted by the FIFO.
REQ-009 SHALL have port err  out  NUM_REQ  one-cycle pulse: the word was dropped (overflow or timeout).
REQ-010 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port wr_en  out  1  FIFO write enable, registered.
REQ-012 SHALL have port data_in  out  FIFO_WIDTH  FIFO write data, registered.
REQ-013 SHALL have port full  in  1  FIFO full flag.
REQ-014 SHALL have port wr_ack  in  1  FIFO write acknowledge.
REQ-015 SHALL have port overflow  in  1  FIFO overflow flag.
REQ-016 SHALL have port drop_cnt  out  8  saturating count of dropped words.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ISSUE, WAIT.
REQ-018 In IDLE with |req and !full, SHALL select a winner round-robin: search starts at (last_id+1) mod NUM_REQ; on the same edge load data_in from the winner's slice, set wr_en=1, latch cur_id, and go to ISSUE.
REQ-019 In IDLE with full=1, SHALL issue nothing and stay in IDLE, regardless of req.
REQ-020 In ISSUE, SHALL hold wr_en=1 for exactly that one cycle, then clear wr_en, clear the timer, and go to WAIT.
REQ-021 In WAIT, wr_ack=1 with overflow=0 SHALL pulse done[cur_id] for one cycle, set last_id=cur_id, and return to IDLE.
REQ-022 In WAIT, overflow=1 (including wr_ack=1 in the same cycle) SHALL pulse err[cur_id], increment drop_cnt, set last_id=cur_id, and return to IDLE.
REQ-023 In WAIT, a timer reaching TIMEOUT cycles with neither wr_ack nor overflow SHALL pulse err[cur_id], increment drop_cnt, set last_id=cur_id, and return to IDLE.
REQ-024 drop_cnt SHALL saturate at 255 and never wrap.
REQ-025 Deassertion of req[cur_id] during ISSUE or WAIT SHALL NOT abort the transaction; done/err is still produced.
REQ-026 wr_en SHALL never be high in two consecutive cycles; minimum spacing between writes is 3 cycles (ISSUE, WAIT, IDLE).
REQ-027 At most one bit of done|err SHALL be high in any cycle.
REQ-028 wr_ack or overflow arriving in IDLE or ISSUE SHALL be ignored.
REQ-029 data_in SHALL hold its last value when wr_en=0.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 rst=1 SHALL immediately force: state=IDLE, wr_en=0, data_in=0, done=0, err=0, busy=0, drop_cnt=0, last_id=NUM_REQ-1 (so requester 0 wins first), timer=0.
REQ-032 Reset asserted during ISSUE or WAIT SHALL abandon the transaction with no done/err pulse.
REQ-033 The first arbitration SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-034 Reset, then req=0001, req_data[0]=16'hA5A5, FIFO acks in the first WAIT cycle -> wr_en high 1 cycle with data_in=A5A5; done=0001 pulsed; busy high 2 cycles.
REQ-035 req=1111 held, FIFO always acks -> grant order 0,1,2,3,0; one done pulse per write; wr_en period 3 cycles.
REQ-036 full=1, req=0010 -> wr_en stays 0 and busy stays 0; after full drops, the write issues on the next edge.
REQ-037 overflow=1 in the first WAIT cycle for requester 2 -> err=0100 pulsed, drop_cnt=1, no done pulse.
REQ-038 No FIFO response -> err pulse after 4 WAIT cycles; repeat 300 times -> drop_cnt=255.
REQ-039 rst pulsed during WAIT -> all outputs zero, no done/err; next arbitration grants requester 0.
